// File: rtl/opl3_write_pacer.sv
// Paced write queue in front of the opl3 register interface: buffers CPU port writes and
// replays them with OPL register-write spacing. Optional macro: OPL3_WRQ_HIGHWATER_EN.
module opl3_write_pacer #(
    parameter int DEPTH       = 16,
    parameter int ADDR_GAP_US = 4,
    parameter int DATA_GAP_US = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce_1us,
    input  logic [1:0]              cpu_addr,
    input  logic [7:0]              cpu_din,
    input  logic                    cpu_we,
    output logic [1:0]              opl_addr,
    output logic [7:0]              opl_din,
    output logic                    opl_we,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    idle,
    output logic                    overflow,
    input  logic                    ovf_clr,
    output logic [$clog2(DEPTH):0]  high_water
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int GAP_MAX = (DATA_GAP_US > ADDR_GAP_US) ? DATA_GAP_US : ADDR_GAP_US;
    localparam int CW      = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_HOLD} state_e;

    logic          we_q, push_q, push_q_d;
    logic [9:0]    push_data_q, push_data_d;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    opl_addr_q, opl_addr_d;
    logic [7:0]    opl_din_q, opl_din_d;
    logic          opl_we_q, opl_we_d;
    logic          overflow_q, overflow_d;
    logic          write, pop, push_ok;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        write       = ~we_q & cpu_we;
        push_q_d    = write;
        push_data_d = write ? {cpu_addr, cpu_din} : push_data_q;
        pop         = (state_q == S_IDLE) && (level_q != '0);
        // A full queue still accepts the push when the head leaves in the same cycle.
        push_ok     = push_q && ((level_q != FULL_LVL) || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q;
        if (ovf_clr)            overflow_d = 1'b0;
        if (push_q && !push_ok) overflow_d = 1'b1;

        state_d    = state_q;
        cnt_d      = cnt_q;
        opl_we_d   = 1'b0;
        opl_addr_d = opl_addr_q;
        opl_din_d  = opl_din_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {opl_addr_d, opl_din_d} = mem[rd_ptr_q];
                    opl_we_d = 1'b1;
                    state_d  = S_STROBE;
                end
            end
            S_STROBE: begin
                cnt_d   = opl_addr_q[0] ? CW'(DATA_GAP_US) : CW'(ADDR_GAP_US);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0)  state_d = S_IDLE;
                else if (ce_1us)  cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the queue storage has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_q;
    end

    // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            opl_addr_q  <= '0;
            opl_din_q   <= '0;
            opl_we_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            we_q        <= cpu_we;
            push_q      <= push_q_d;
            push_data_q <= push_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opl_addr_q  <= opl_addr_d;
            opl_din_q   <= opl_din_d;
            opl_we_q    <= opl_we_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef OPL3_WRQ_HIGHWATER_EN
    logic [LW-1:0] hw_q, hw_d;

    always_comb begin
        hw_d = hw_q;
        if (ovf_clr)              hw_d = level_q;
        else if (level_q > hw_q)  hw_d = level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hw_q <= '0;
        else        hw_q <= hw_d;
    end

    assign high_water = hw_q;
`else
    assign high_water = '0;
`endif

    assign opl_addr   = opl_addr_q;
    assign opl_din    = opl_din_q;
    assign opl_we     = opl_we_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign idle       = (level_q == '0) && (state_q == S_IDLE) && !push_q;

endmodule

// File: tb/tb_opl3_write_pacer.sv
// Scoreboard bench for opl3_write_pacer: expected deliveries are queued at issue time and a
// monitor compares every opl_we pulse against the queue and the minimum-spacing rule.
module tb_opl3_write_pacer;

    localparam int DEPTH = 16;
    localparam int AGAP  = 4;
    localparam int DGAP  = 23;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce_1us = 1'b0;
    logic [1:0]    cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic          cpu_we = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [1:0]    opl_addr;
    logic [7:0]    opl_din;
    logic          opl_we;
    logic [LW-1:0] fifo_level;
    logic          idle;
    logic          overflow;
    logic [LW-1:0] high_water;

    opl3_write_pacer #(.DEPTH(DEPTH), .ADDR_GAP_US(AGAP), .DATA_GAP_US(DGAP)) dut (
        .clk(clk), .rst_n(rst_n), .ce_1us(ce_1us),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .opl_addr(opl_addr), .opl_din(opl_din), .opl_we(opl_we),
        .fifo_level(fifo_level), .idle(idle), .overflow(overflow),
        .ovf_clr(ovf_clr), .high_water(high_water)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ticks = 0;
    int gap_req = 0;
    bit have_prev = 1'b0;
    bit prev_we = 1'b0;
    int pulse_cnt = 0;
    int pulse_cyc = -1;
    logic [9:0] sb [$];

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // 1 us strobe every 10 clocks, driven just after the rising edge.
    initial begin
        int div = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            ce_1us = (div == 9);
            div = (div == 9) ? 0 : div + 1;
        end
    end

    // Monitor: every pulse must match the oldest expected write and respect the previous gap.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ticks = 0; have_prev = 1'b0; prev_we = 1'b0;
            end else begin
                if (opl_we) begin
                    logic [9:0] exp;
                    if (prev_we) check("we_width", 1'b0, 2, 1);
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 1'b0, {opl_addr, opl_din}, -1);
                    end else begin
                        exp = sb.pop_front();
                        check("opl_addr", opl_addr === exp[9:8], opl_addr, exp[9:8]);
                        check("opl_din", opl_din === exp[7:0], opl_din, exp[7:0]);
                    end
                    if (have_prev) check("spacing", ticks >= gap_req, ticks, gap_req);
                    gap_req   = opl_addr[0] ? DGAP : AGAP;
                    have_prev = 1'b1;
                    ticks     = 0;
                    pulse_cnt++;
                    pulse_cyc = cyc;
                end else if (ce_1us) begin
                    ticks++;
                end
                prev_we = opl_we;
            end
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // One write edge: we high for one cycle, then low for one cycle.
    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
        sync();
        cpu_we = 1'b0;
        sync();
    endtask

    task automatic issue(input logic [1:0] a, input logic [7:0] d);
        sb.push_back({a, d});
        cpu_write(a, d);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(idle && sb.size() == 0) && n < budget) begin
            @(negedge clk); n++;
        end
        check("drain", idle && sb.size() == 0, sb.size(), 0);
        sync();
    endtask

    task automatic pulse_ovf_clr();
        ovf_clr = 1'b1; sync(); ovf_clr = 1'b0; sync();
    endtask

    initial begin
        int c0, n, snap;

        // Reset state
        #2;
        check("rst_opl_we", opl_we === 1'b0, opl_we, 0);
        check("rst_level", fifo_level === '0, fifo_level, 0);
        check("rst_idle", idle === 1'b1, idle, 1);
        check("rst_overflow", overflow === 1'b0, overflow, 0);
        check("rst_high_water", high_water === '0, high_water, 0);
        repeat (3) sync();
        rst_n = 1'b1;
        repeat (3) sync();

        // Single index write: pulse 3 cycles after the edge, idle again after 4 ticks
        c0 = cyc;
        issue(2'd0, 8'h20);
        n = 0;
        while (pulse_cnt == 0 && n < 50) begin @(negedge clk); n++; end
        check("latency", pulse_cyc == c0 + 3, pulse_cyc - c0, 3);
        n = 0;
        while (!idle && n < 200) begin @(negedge clk); n++; end
        #1;
        check("idle_after_gap", idle && ticks == AGAP, ticks, AGAP);
        wait_drain(100);

        // Burst idx/data/idx/data within 10 clocks
        issue(2'd0, 8'hB0);
        issue(2'd1, 8'h31);
        issue(2'd0, 8'hA0);
        issue(2'd1, 8'h44);
        wait_drain(2000);

        // 20 back-to-back data writes: 1 in flight + 16 queued, remaining dropped
        for (int i = 1; i <= 20; i++) begin
            if (i <= DEPTH + 1) sb.push_back({2'd1, 8'(i)});
            cpu_write(2'd1, 8'(i));
        end
        @(negedge clk);
        check("ovf_level", fifo_level == LW'(DEPTH), fifo_level, DEPTH);
        check("ovf_set", overflow === 1'b1, overflow, 1);
`ifdef OPL3_WRQ_HIGHWATER_EN
        check("hw_full", high_water == LW'(DEPTH), high_water, DEPTH);
`else
        check("hw_tied", high_water === '0, high_water, 0);
`endif
        sync();
        pulse_ovf_clr();
        check("ovf_clr", overflow === 1'b0, overflow, 0);

        // Push landing exactly on a pop with a full queue
        snap = pulse_cnt;
        n = 0;
        while (pulse_cnt == snap && n < 400) begin @(negedge clk); n++; end
        check("pulse2_seen", pulse_cnt > snap, pulse_cnt - snap, 1);
        sync();
        issue(2'd1, 8'hE1);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (ticks < DGAP && n < 400);
        check("hold_ticks", ticks == DGAP, ticks, DGAP);
        sync();
        sb.push_back({2'd1, 8'hE2});
        cpu_addr = 2'd1; cpu_din = 8'hE2; cpu_we = 1'b1;
        sync();
        cpu_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("full_pop_pulse", opl_we === 1'b1, opl_we, 1);
        check("full_push_level", fifo_level == LW'(DEPTH), fifo_level, DEPTH);
        check("full_push_no_ovf", overflow === 1'b0, overflow, 0);
        sync();
        wait_drain(8000);

        // Reset mid-HOLD with 5 entries queued
        for (int i = 0; i < 6; i++) issue(2'd1, 8'h50 + 8'(i));
        repeat (20) sync();
        check("pre_rst_level", fifo_level == LW'(5), fifo_level, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_opl_we", opl_we === 1'b0, opl_we, 0);
        check("mid_rst_outputs", opl_addr === '0 && opl_din === '0, {opl_addr, opl_din}, 0);
        check("mid_rst_level", fifo_level === '0, fifo_level, 0);
        check("mid_rst_idle", idle === 1'b1, idle, 1);
        sb.delete();
        repeat (3) sync();
        rst_n = 1'b1;
        snap = pulse_cnt;
        repeat (300) sync();
        check("no_pulse_after_rst", pulse_cnt == snap, pulse_cnt - snap, 0);

        // High-water tracking with 7 queued behind one in flight
        pulse_ovf_clr();
        for (int i = 0; i < 8; i++) issue(2'd1, 8'h70 + 8'(i));
        wait_drain(4000);
`ifdef OPL3_WRQ_HIGHWATER_EN
        check("hw_seven", high_water == LW'(7), high_water, 7);
`else
        check("hw_zero", high_water === '0, high_water, 0);
`endif

        // Randomized traffic, paced so the queue never overflows
        for (int i = 0; i < 60; i++) begin
            logic [1:0] a;
            logic [7:0] d;
            repeat ($urandom_range(0, 25)) sync();
            n = 0;
            while (sb.size() >= DEPTH - 2 && n < 2000) begin sync(); n++; end
            if (n >= 2000) check("rand_pace_timeout", 1'b0, sb.size(), DEPTH - 2);
            a = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            issue(a, d);
        end
        wait_drain(20000);
        check("rand_no_ovf", overflow === 1'b0, overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
